// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point add/subtract unit.
//   - default field widths (single precision) and the packed word width
//   - canonical quiet NaN for the default format
//   - flag bit positions within the 4-bit flags word
//   - FSM state encoding
//   - small classification helpers and a flag packer
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

  localparam logic [FP_W-1:0] FP_QNAN =
    {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

  // Bit positions inside flags = {invalid, overflow, underflow, inexact}
  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

  // Helpers take field summaries so they stay independent of EXP_W/MAN_W.
  function automatic logic is_nan(input logic exp_ones, input logic frac_nz);
    return exp_ones & frac_nz;
  endfunction

  function automatic logic is_inf(input logic exp_ones, input logic frac_nz);
    return exp_ones & ~frac_nz;
  endfunction

  // Denormals are flushed, so a zero exponent alone marks a zero operand.
  function automatic logic is_zero(input logic exp_zero);
    return exp_zero;
  endfunction

  function automatic logic [3:0] pack_flags(input logic inv, input logic ovf,
                                            input logic unf, input logic inx);
    logic [3:0] f;
    f                = '0;
    f[FLG_INVALID]   = inv;
    f[FLG_OVERFLOW]  = ovf;
    f[FLG_UNDERFLOW] = unf;
    f[FLG_INEXACT]   = inx;
    return f;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalised mantissa.
// Ports:
//   exp_in   : biased exponent, one extra bit of headroom
//   man_in   : hidden bit + fraction (MAN_W+1 bits)
//   g, r, s  : guard, round and sticky bits below the fraction LSB
//   exp_out  : rounded exponent (all-ones on overflow)
//   frac_out : rounded fraction (zero on overflow)
//   overflow : rounded exponent reached all-ones
//   inexact  : any discarded bit was set, or overflow
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [EXP_W:0]   exp_in,
  input  logic [MAN_W:0]   man_in,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] frac_out,
  output logic             overflow,
  output logic             inexact
);

  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  // Round up when above half, or exactly half and the LSB is odd.
  function automatic logic rne_up(input logic lsb, input logic gb,
                                  input logic rb, input logic sb);
    return gb & (rb | sb | lsb);
  endfunction

  logic [MAN_W+1:0] man_sum;
  logic [EXP_W:0]   exp_sum;

  always_comb begin
    man_sum  = {1'b0, man_in} + {{(MAN_W+1){1'b0}}, rne_up(man_in[0], g, r, s)};
    // A carry out of the mantissa means it became exactly 10.0...0
    exp_sum  = exp_in + {{EXP_W{1'b0}}, man_sum[MAN_W+1]};
    overflow = (exp_sum >= EXP_MAX);
    inexact  = g | r | s | overflow;
    if (overflow) begin
      exp_out  = '1;
      frac_out = '0;
    end else begin
      exp_out  = exp_sum[EXP_W-1:0];
      frac_out = man_sum[MAN_W+1] ? man_sum[MAN_W:1] : man_sum[MAN_W-1:0];
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with valid/ready handshake.
// Normalisation shifts one place per cycle, so latency depends on the data.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only when idle)
//   op                   : 0 = a+b, 1 = a-b
//   a, b                 : packed {sign, exponent, fraction} operands
//   out_valid / out_ready: result handshake, result held until accepted
//   result               : packed result
//   flags                : {invalid, overflow, underflow, inexact}
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  // Extended mantissa: {carry, hidden, fraction, G, R, S}
  localparam int XW = MAN_W + 5;
  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W-1:0] MAX_SH  = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W:0]   EXP_ONE = (EXP_W+1)'(1);

  state_t state, state_n;

  // Working operands: X ends up as the larger magnitude / accumulator
  logic             s_x, s_y;
  logic [EXP_W:0]   e_x;
  logic [EXP_W-1:0] e_y;
  logic [XW-1:0]    m_x, m_y;

  // Operand decode and special-value short cut
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             spec_hit, spec_inv;
  logic [W-1:0]     spec_res;

  always_comb begin
    a_s    = a[W-1];
    a_e    = a[W-2:MAN_W];
    a_f    = a[MAN_W-1:0];
    b_s    = b[W-1] ^ op;
    b_e    = b[W-2:MAN_W];
    b_f    = b[MAN_W-1:0];
    a_nan  = is_nan(&a_e, |a_f);
    b_nan  = is_nan(&b_e, |b_f);
    a_inf  = is_inf(&a_e, |a_f);
    b_inf  = is_inf(&b_e, |b_f);
    a_zero = is_zero(a_e == '0);
    b_zero = is_zero(b_e == '0);

    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else if (a_inf && b_inf && (a_s != b_s)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = {a_s, a_e, a_f};
    end else if (b_inf) begin
      spec_res = {b_s, b_e, b_f};
    end else if (a_zero && b_zero) begin
      spec_res = {a_s & b_s, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_res = {b_s, b_e, b_f};
    end else if (b_zero) begin
      spec_res = {a_s, a_e, a_f};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Alignment: pick the larger magnitude, shift the smaller into G/R/S
  logic             swap, big_s, sml_s, lost;
  logic [EXP_W-1:0] big_e, sml_e, diff;
  logic [XW-1:0]    big_m, sml_m, sml_sh, y_al;

  always_comb begin
    swap   = {e_y, m_y} > {e_x[EXP_W-1:0], m_x};
    big_s  = swap ? s_y : s_x;
    sml_s  = swap ? s_x : s_y;
    big_e  = swap ? e_y : e_x[EXP_W-1:0];
    sml_e  = swap ? e_x[EXP_W-1:0] : e_y;
    big_m  = swap ? m_y : m_x;
    sml_m  = swap ? m_x : m_y;
    diff   = big_e - sml_e;
    sml_sh = sml_m >> diff;
    lost   = |(sml_m & ~({XW{1'b1}} << diff));
    // Beyond MAN_W+3 the whole mantissa lands below S: only stickiness remains
    if (diff > MAX_SH) y_al = {{(XW-1){1'b0}}, 1'b1};
    else               y_al = {sml_sh[XW-1:1], sml_sh[0] | lost};
  end

  // Add / subtract and normalisation decisions
  logic [XW-1:0] sum_m;
  logic          sum_zero, carry, hid, exp_gt1, norm_left, norm_flush;

  always_comb begin
    sum_m      = (s_x ^ s_y) ? (m_x - m_y) : (m_x + m_y);
    sum_zero   = (sum_m == '0);
    carry      = m_x[XW-1];
    hid        = m_x[XW-2];
    exp_gt1    = (e_x > EXP_ONE);
    norm_left  = !carry && !hid && exp_gt1;
    norm_flush = !carry && !hid && !exp_gt1;
  end

  logic [EXP_W-1:0] rnd_e;
  logic [MAN_W-1:0] rnd_f;
  logic             rnd_ovf, rnd_inx;

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .exp_in   (e_x),
    .man_in   (m_x[XW-2:3]),
    .g        (m_x[2]),
    .r        (m_x[1]),
    .s        (m_x[0]),
    .exp_out  (rnd_e),
    .frac_out (rnd_f),
    .overflow (rnd_ovf),
    .inexact  (rnd_inx)
  );

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (in_valid) state_n = spec_hit ? DONE : ALIGN;
      ALIGN: state_n = ADD;
      ADD:   state_n = sum_zero ? DONE : NORM;
      NORM: begin
        if (norm_flush)              state_n = DONE;
        else if (!carry && hid)      state_n = ROUND;
      end
      ROUND: state_n = DONE;
      DONE:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Result/flags are architecturally visible and cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && spec_hit) begin
          result <= spec_res;
          flags  <= pack_flags(spec_inv, 1'b0, 1'b0, 1'b0);
        end
        ADD: if (sum_zero) begin
          result <= '0;
          flags  <= '0;
        end
        NORM: if (norm_flush) begin
          result <= {s_x, {(W-1){1'b0}}};
          flags  <= pack_flags(1'b0, 1'b0, 1'b1, 1'b1);
        end
        ROUND: begin
          result <= {s_x, rnd_e, rnd_f};
          flags  <= pack_flags(1'b0, rnd_ovf, 1'b0, rnd_inx);
        end
        default: ;
      endcase
    end
  end

  // Working datapath, no reset needed: every path reloads it on accept
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        s_x <= a_s;
        e_x <= {1'b0, a_e};
        m_x <= {2'b01, a_f, 3'b000};
        s_y <= b_s;
        e_y <= b_e;
        m_y <= {2'b01, b_f, 3'b000};
      end
      ALIGN: begin
        s_x <= big_s;
        e_x <= {1'b0, big_e};
        m_x <= big_m;
        s_y <= sml_s;
        m_y <= y_al;
      end
      ADD: m_x <= sum_m;
      NORM: begin
        if (carry) begin
          m_x <= {1'b0, m_x[XW-1:2], m_x[1] | m_x[0]};
          e_x <= e_x + EXP_ONE;
        end else if (norm_left) begin
          m_x <= {m_x[XW-2:0], 1'b0};
          e_x <= e_x - EXP_ONE;
        end
      end
      default: ;
    endcase
  end

endmodule
